// File: rtl/mont_param_gen.sv
// Per-modulus Montgomery constants: n = -N^-1 mod 2^WORD_WIDTH by bitwise Hensel lifting,
// and R2 = 2^(2*NUM_WIDTH) mod N by repeated modular doubling. Fixed, data-independent latency.
module mont_param_gen #(
    parameter int NUM_WIDTH  = 256,
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(2*NUM_WIDTH+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_WIDTH-1:0]  N,
    output logic                  busy,
    output logic                  ready,
    output logic                  err,
    output logic [WORD_WIDTH-1:0] n,
    output logic [NUM_WIDTH-1:0]  R2,
    output logic [2:0]            dbg_state
);

    // Handshake: start is only looked at in ST_WAIT, and N is captured on that same edge.
    // busy covers INIT/NINV/R2SQ; ready pulses for one cycle in ST_DONE with err, n and R2 valid,
    // and those three outputs hold until the next completion or reset.

    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_INIT = 3'd1,
        ST_NINV = 3'd2,
        ST_R2SQ = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int IDX_W = $clog2(WORD_WIDTH);
    localparam logic [CNT_WIDTH-1:0] NINV_LAST = CNT_WIDTH'(WORD_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] R2SQ_LAST = CNT_WIDTH'(2*NUM_WIDTH - 1);

    state_t                state;
    state_t                next_state;
    logic [NUM_WIDTH-1:0]  n_reg;
    logic [WORD_WIDTH-1:0] y;
    logic [NUM_WIDTH-1:0]  r;
    logic                  err_flag;
    logic [CNT_WIDTH-1:0]  cnt;

    logic [WORD_WIDTH-1:0] p;
    logic [IDX_W-1:0]      bit_idx;
    logic [NUM_WIDTH:0]    t;
    logic [NUM_WIDTH:0]    t_sub;
    logic [NUM_WIDTH-1:0]  r_next;

    // y stays an inverse of N modulo 2^cnt; bit cnt of N*y decides whether y needs that bit.
    assign p       = n_reg[WORD_WIDTH-1:0] * y;
    assign bit_idx = cnt[IDX_W-1:0];

    // r < N always holds, so the doubled value fits in NUM_WIDTH+1 bits and one subtract reduces it.
    assign t      = {r, 1'b0};
    assign t_sub  = t - {1'b0, n_reg};
    assign r_next = (t >= {1'b0, n_reg}) ? t_sub[NUM_WIDTH-1:0] : t[NUM_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_WAIT: if (start) next_state = ST_INIT;
            ST_INIT: next_state = ST_NINV;
            ST_NINV: if (cnt == NINV_LAST) next_state = ST_R2SQ;
            ST_R2SQ: if (cnt == R2SQ_LAST) next_state = ST_DONE;
            ST_DONE: next_state = ST_WAIT;
            default: next_state = ST_WAIT;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        ready     = 1'b0;
        dbg_state = state;
        case (state)
            ST_INIT, ST_NINV, ST_R2SQ: busy  = 1'b1;
            ST_DONE:                   ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg    <= '0;
            y        <= '0;
            r        <= '0;
            err_flag <= 1'b0;
            cnt      <= '0;
            n        <= '0;
            R2       <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (start) n_reg <= N;
                end
                ST_INIT: begin
                    y        <= WORD_WIDTH'(1);
                    r        <= (n_reg == NUM_WIDTH'(1)) ? '0 : NUM_WIDTH'(1);
                    err_flag <= ~n_reg[0] | (n_reg == NUM_WIDTH'(1));
                    cnt      <= CNT_WIDTH'(1);
                end
                ST_NINV: begin
                    if (p[bit_idx]) y[bit_idx] <= 1'b1;
                    if (cnt == NINV_LAST) cnt <= '0;
                    else                  cnt <= cnt + CNT_WIDTH'(1);
                end
                ST_R2SQ: begin
                    r <= r_next;
                    if (cnt == R2SQ_LAST) begin
                        cnt <= '0;
                        n   <= err_flag ? '0 : (~y + WORD_WIDTH'(1));
                        R2  <= err_flag ? '0 : r_next;
                        err <= err_flag;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_param_gen.sv
// Directed bench for mont_param_gen at NUM_WIDTH=64, WORD_WIDTH=32: a driver pushes expected
// results into a queue and an independent monitor compares them whenever ready pulses.
module tb_mont_param_gen;
    localparam int NW  = 64;
    localparam int WW  = 32;
    localparam int LAT = WW + 2*NW;
    localparam int EW  = 32 + WW + 1 + WW + NW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NW-1:0] N;
    logic          busy;
    logic          ready;
    logic          err;
    logic [WW-1:0] n;
    logic [NW-1:0] R2;
    logic [2:0]    dbg_state;

    mont_param_gen #(.NUM_WIDTH(NW), .WORD_WIDTH(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .N(N),
        .busy(busy), .ready(ready), .err(err), .n(n), .R2(R2), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time expired, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // -N^-1 mod 2^WW by Newton iteration; odd a is its own inverse mod 8, each step doubles the bits.
    function automatic logic [WW-1:0] neg_inv(input logic [WW-1:0] a);
        logic [WW-1:0] x;
        x = a;
        for (int i = 0; i < 5; i++) x = x * (WW'(2) - a * x);
        return -x;
    endfunction

    task automatic push_exp(input int s, input logic [NW-1:0] m, input logic ee,
                            input logic [WW-1:0] en, input logic [NW-1:0] er);
        exp_q.push_back({32'(s + LAT), m[WW-1:0], ee, en, er});
    endtask

    always @(negedge clk) begin
        if (!rst && ready) begin
            ready_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready at cycle %0d, required none", cyc);
            end else begin
                logic [EW-1:0] e;
                logic [WW-1:0] prod;
                e = exp_q.pop_front();
                check("latency", 128'(cyc), 128'(e[EW-1 -: 32]));
                check("err", 128'(err), 128'(e[NW+WW]));
                check("n", 128'(n), 128'(e[NW+WW-1 -: WW]));
                check("R2", 128'(R2), 128'(e[NW-1:0]));
                if (!e[NW+WW]) begin
                    prod = n * e[EW-33 -: WW];
                    check("n_times_N", 128'(prod), 128'({WW{1'b1}}));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [NW-1:0] m, input logic ee, input logic [WW-1:0] en,
                         input logic [NW-1:0] er, output int s);
        @(negedge clk);
        start = 1'b1;
        N     = m;
        @(posedge clk);
        #1;
        s = cyc;
        push_exp(s, m, ee, en, er);
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        N     = {$urandom, $urandom};
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 3*LAT + 10;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("drain_pending", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_ready"}, 128'(ready), 128'(0));
        check({tag, "_err"}, 128'(err), 128'(0));
        check({tag, "_n"}, 128'(n), 128'(0));
        check({tag, "_R2"}, 128'(R2), 128'(0));
        check({tag, "_state"}, 128'(dbg_state), 128'(0));
    endtask

    task automatic run_job(input logic [NW-1:0] m, input logic ee, input logic [WW-1:0] en,
                           input logic [NW-1:0] er);
        int s;
        issue(m, ee, en, er, s);
        check("busy_in_init", 128'(busy), 128'(1));
        check("state_init", 128'(dbg_state), 128'(1));
        release_start();
        drain();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s;
        int rc;
        rst   = 1'b1;
        start = 1'b0;
        N     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        // Odd moduli with hand-derived constants: 3^-1=0xAAAAAAAB, 5^-1=0xCCCCCCCD, 7^-1=0xB6DB6DB7.
        run_job(64'd3, 1'b0, 32'h5555_5555, 64'd1);
        run_job(64'hFFFF_FFFF_FFFF_FFC5, 1'b0, neg_inv(32'hFFFF_FFC5), 64'hD99);
        run_job(64'd5, 1'b0, 32'h3333_3333, 64'd1);
        run_job(64'd7, 1'b0, 32'h4924_9249, 64'd4);
        run_job(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h0000_0001, 64'd1);

        // Error cases: even modulus and N == 1.
        run_job(64'h10, 1'b1, 32'h0, 64'h0);
        run_job(64'd1, 1'b1, 32'h0, 64'h0);

        // start and N changes mid-job are ignored; exactly one ready.
        rc = ready_cnt;
        issue(64'd7, 1'b0, 32'h4924_9249, 64'd4, s);
        release_start();
        wait_until(s + 50);
        @(negedge clk);
        start = 1'b1;
        N     = 64'd5;
        @(negedge clk);
        start = 1'b0;
        N     = 64'd11;
        drain();
        repeat (LAT + 10) @(posedge clk);
        check("single_ready", 128'(ready_cnt - rc), 128'(1));

        // Reset mid-job aborts it with no ready pulse, and outputs return to zero.
        issue(64'd3, 1'b0, 32'h5555_5555, 64'd1, s);
        release_start();
        wait_until(s + 70);
        rc = ready_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check_idle("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 10) @(posedge clk);
        check("aborted_no_ready", 128'(ready_cnt - rc), 128'(0));
        run_job(64'd3, 1'b0, 32'h5555_5555, 64'd1);

        // start held through DONE restarts after exactly one WAIT cycle.
        issue(64'd5, 1'b0, 32'h3333_3333, 64'd1, s);
        wait_until(s + LAT + 2);
        check("restart_state", 128'(dbg_state), 128'(1));
        push_exp(s + LAT + 2, 64'd5, 1'b0, 32'h3333_3333, 64'd1);
        release_start();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
